// File: rtl/switch_debounce_4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_debounce_4 : 4-channel switch synchroniser, debouncer, press strobe|
// | Optional latch-toggle outputs: SWITCH_DEBOUNCE_TOGGLE_EN                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module switch_debounce_4 #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int CNT_W          = 18
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  output logic o_Switch_1,
  output logic o_Switch_2,
  output logic o_Switch_3,
  output logic o_Switch_4,
  output logic o_Press_1,
  output logic o_Press_2,
  output logic o_Press_3,
  output logic o_Press_4,
  output logic o_Toggle_1,
  output logic o_Toggle_2,
  output logic o_Toggle_3,
  output logic o_Toggle_4
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  generate
    if (DEBOUNCE_LIMIT < 1 || DEBOUNCE_LIMIT > (1 << 20)) begin : g_bad_limit
      $error("switch_debounce_4: DEBOUNCE_LIMIT out of range 1..2^20");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_LIMIT - 1)) begin : g_bad_cnt_w
      $error("switch_debounce_4: CNT_W too narrow for DEBOUNCE_LIMIT-1");
    end
  endgenerate

  logic [3:0] w_pin;
  logic [3:0] w_switch;
  logic [3:0] w_press;
  logic [3:0] w_toggle;

  assign w_pin = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  generate
    for (genvar g = 0; g < 4; g++) begin : g_chan
      logic             r_sync1;
      logic             r_sync2;
      logic             r_switch;
      logic             r_press;
      logic [CNT_W-1:0] r_cnt;

      // The counter only runs while the synchronised level disagrees with the
      // output, so any return to the current level restarts it from zero.
      always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
          r_sync1  <= 1'b0;
          r_sync2  <= 1'b0;
          r_switch <= 1'b0;
          r_press  <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_sync1 <= w_pin[g];
          r_sync2 <= r_sync1;
          r_press <= 1'b0;
          if (r_sync2 != r_switch) begin
            if (r_cnt == c_LAST) begin
              r_switch <= r_sync2;
              r_press  <= r_sync2;
              r_cnt    <= '0;
            end else begin
              r_cnt <= r_cnt + c_ONE;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      assign w_switch[g] = r_switch;
      assign w_press[g]  = r_press;

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
      logic r_toggle;

      always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
          r_toggle <= 1'b0;
        end else if (r_press) begin
          r_toggle <= ~r_toggle;
        end
      end

      assign w_toggle[g] = r_toggle;
`else
      assign w_toggle[g] = r_switch;
`endif
    end
  endgenerate

  assign o_Switch_1 = w_switch[0];
  assign o_Switch_2 = w_switch[1];
  assign o_Switch_3 = w_switch[2];
  assign o_Switch_4 = w_switch[3];
  assign o_Press_1  = w_press[0];
  assign o_Press_2  = w_press[1];
  assign o_Press_3  = w_press[2];
  assign o_Press_4  = w_press[3];
  assign o_Toggle_1 = w_toggle[0];
  assign o_Toggle_2 = w_toggle[1];
  assign o_Toggle_3 = w_toggle[2];
  assign o_Toggle_4 = w_toggle[3];

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_4.sv
`default_nettype none
// Testbench for switch_debounce_4 with DEBOUNCE_LIMIT=4: directed cases then
// randomized bouncing pins against a window-based reference model.
module tb_switch_debounce_4;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pins;
  logic [3:0] sw, pr, tg;

  always #5 clk = ~clk;

  switch_debounce_4 #(.DEBOUNCE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Switch_1(pins[0]), .i_Switch_2(pins[1]),
    .i_Switch_3(pins[2]), .i_Switch_4(pins[3]),
    .o_Switch_1(sw[0]), .o_Switch_2(sw[1]), .o_Switch_3(sw[2]), .o_Switch_4(sw[3]),
    .o_Press_1(pr[0]), .o_Press_2(pr[1]), .o_Press_3(pr[2]), .o_Press_4(pr[3]),
    .o_Toggle_1(tg[0]), .o_Toggle_2(tg[1]), .o_Toggle_3(tg[2]), .o_Toggle_4(tg[3])
  );

  // Reference: the synchronised level is the pin two edges back (zero if
  // either of those edges was in reset); an output flips once the last LIMIT
  // synchronised samples all disagree with it.
  logic [3:0] m_out, m_press, m_tog, prev_pin;
  logic       prev_rst;
  logic [3:0] s2h[$];
  int         n_vec  = 0;
  int         n_miss = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] p);
    logic [3:0] s2;
    logic [3:0] flip;
    s2   = (r || prev_rst) ? 4'b0000 : prev_pin;
    flip = 4'b0000;
    if (s2h.size() >= LIMIT) begin
      for (int ch = 0; ch < 4; ch++) begin
        flip[ch] = 1'b1;
        for (int k = 1; k <= LIMIT; k++)
          if (s2h[s2h.size() - k][ch] == m_out[ch]) flip[ch] = 1'b0;
      end
    end
    if (r) begin
      m_out = 4'b0; m_press = 4'b0; m_tog = 4'b0;
    end else begin
      m_tog   = m_tog ^ m_press;
      m_press = flip & ~m_out;
      m_out   = m_out ^ flip;
    end
    s2h.push_back(s2);
    if (s2h.size() > LIMIT) void'(s2h.pop_front());
    prev_rst = r;
    prev_pin = p;
  endtask

  task automatic tick(input logic r, input logic [3:0] p);
    logic [3:0] exp_tog;
    rst  = r;
    pins = p;
    @(posedge clk);
    model_edge(r, p);
    @(negedge clk);
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    exp_tog = m_tog;
`else
    exp_tog = m_out;
`endif
    chk("switch", sw, m_out);
    chk("press", pr, m_press);
    chk("toggle", tg, exp_tog);
  endtask

  int np;
  int hold[4];
  logic [3:0] rp;

  initial begin
    rst = 1'b1; pins = 4'b0000;
    m_out = '0; m_press = '0; m_tog = '0; prev_pin = '0; prev_rst = 1'b1;
    @(negedge clk);

    // T1: reset with all pins high, then release
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 4'b1111);
      chk("t1_rst_sw", sw, 4'b0000);
      chk("t1_rst_pr", pr, 4'b0000);
    end
    for (int i = 1; i <= 7; i++) begin
      tick(1'b0, 4'b1111);
      if (i < 6) chk("t1_early_sw", sw, 4'b0000);
      if (i == 6) begin
        chk("t1_sw", sw, 4'b1111);
        chk("t1_pr", pr, 4'b1111);
      end
      if (i == 7) chk("t1_pr_end", pr, 4'b0000);
    end

    // T2: clean press on channel 2
    repeat (8) tick(1'b0, 4'b0000);
    for (int i = 1; i <= 7; i++) begin
      tick(1'b0, 4'b0010);
      if (i == 5) chk("t2_sw5", sw, 4'b0000);
      if (i == 6) begin
        chk("t2_sw6", sw, 4'b0010);
        chk("t2_pr6", pr, 4'b0010);
      end
      if (i == 7) chk("t2_pr7", pr, 4'b0000);
    end

    // T3: bounce on channel 1
    repeat (8) tick(1'b0, 4'b0000);
    np = 0;
    begin
      logic [11:0] pat;
      pat = 12'b1111_1111_0111; // applied LSB first: 1,1,1,0 then ones
      for (int i = 0; i < 12; i++) begin
        tick(1'b0, {3'b000, pat[i]});
        if (pr[0]) np++;
      end
    end
    chk("t3_presses", 4'(np), 4'd1);
    chk("t3_sw", sw, 4'b0001);

    // T4: 3-cycle glitch on channel 3
    repeat (8) tick(1'b0, 4'b0000);
    repeat (3) tick(1'b0, 4'b0100);
    repeat (8) begin
      tick(1'b0, 4'b0000);
      chk("t4_sw", sw, 4'b0000);
    end

    // T5: simultaneous release, then channels 1 and 4 rise together
    repeat (8) tick(1'b0, 4'b1111);
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 4'b0000);
      if (i == 5) chk("t5_sw5", sw, 4'b1111);
      if (i == 6) begin
        chk("t5_sw6", sw, 4'b0000);
        chk("t5_pr6", pr, 4'b0000);
      end
    end
    for (int i = 1; i <= 7; i++) begin
      tick(1'b0, 4'b1001);
      if (i == 6) chk("t5_pr_pair", pr, 4'b1001);
    end

    // T6: three presses on channel 4
    repeat (8) tick(1'b0, 4'b0000);
    repeat (3) begin
      repeat (8) tick(1'b0, 4'b1000);
      repeat (8) tick(1'b0, 4'b0000);
    end

    // Randomized bouncing pins with occasional reset
    rp = 4'b0000;
    for (int ch = 0; ch < 4; ch++) hold[ch] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (hold[ch] == 0) begin
          rp[ch]   = 1'($urandom_range(0, 1));
          hold[ch] = int'($urandom_range(1, 8));
        end
        hold[ch]--;
      end
      tick(($urandom_range(0, 79) == 0), rp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
